// File: rtl/pxs_ball_ctrl.sv
// Per-frame ball motion sequencer: steps the ball on VS rising edges, bounces it
// off the screen edges and flags goals. Optional serve hold-off with BALL_SERVE_EN.
module pxs_ball_ctrl #(
  parameter int unsigned SCREEN_W   = 640,
  parameter int unsigned SCREEN_H   = 480,
  parameter int unsigned SIZE_BALL  = 10,
  parameter int unsigned STEP       = 2,
  parameter int unsigned FRAME_DIV  = 1,
  parameter int unsigned SERVE_WAIT = 60
) (
  input  logic        px_clk,
  input  logic        reset_n,
  input  logic [25:0] RGBStr_i,
  input  logic        run,
  output logic [9:0]  pos_x,
  output logic [9:0]  pos_y,
  output logic        goal_l,
  output logic        goal_r,
  output logic        bounce
);

  localparam logic [1:0]  StWait    = 2'd0;
  localparam logic [1:0]  StMove    = 2'd1;
  localparam logic [10:0] StepW     = 11'(STEP);
  localparam logic [10:0] MaxX      = 11'(SCREEN_W - SIZE_BALL);
  localparam logic [10:0] MaxY      = 11'(SCREEN_H - SIZE_BALL);
  localparam logic [9:0]  CtrX      = 10'((SCREEN_W - SIZE_BALL) / 2);
  localparam logic [9:0]  CtrY      = 10'((SCREEN_H - SIZE_BALL) / 2);
  localparam logic [7:0]  FrameLast = 8'(FRAME_DIV - 1);

  logic [1:0]  state_q, state_d;
  logic        vs_q;
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  logic [9:0]  pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic        dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic        goal_l_q, goal_l_d, goal_r_q, goal_r_d, bounce_q, bounce_d;
  logic        tick;
  logic [11:0] x_res, y_res;
  logic        unused_rgb;

  assign tick       = RGBStr_i[1] & ~vs_q;
  assign unused_rgb = ^{RGBStr_i[25:2], RGBStr_i[0]};

  // Returns {reflected, new_dir, new_pos}; dir 1 = increasing coordinate.
  function automatic logic [11:0] axis_step(input logic [9:0] pos, input logic dir_pos,
                                            input logic [10:0] max_pos);
    logic [10:0] cur, sum, diff;
    cur       = {1'b0, pos};
    sum       = cur + StepW;
    diff      = cur - StepW;
    axis_step = {1'b0, dir_pos, pos};
    if (dir_pos) begin
      if (sum >= max_pos) axis_step = {1'b1, 1'b0, max_pos[9:0]};
      else                axis_step = {1'b0, 1'b1, sum[9:0]};
    end else begin
      if (cur <= StepW) axis_step = {1'b1, 1'b1, 10'd0};
      else              axis_step = {1'b0, 1'b0, diff[9:0]};
    end
  endfunction

  assign x_res = axis_step(pos_x_q, dir_x_q, MaxX);
  assign y_res = axis_step(pos_y_q, dir_y_q, MaxY);

`ifdef BALL_SERVE_EN
  localparam logic [1:0]  StServe   = 2'd2;
  localparam logic [15:0] ServeLast = 16'(SERVE_WAIT - 1);
  logic [15:0] serve_cnt_q, serve_cnt_d;
`else
  logic unused_serve_wait;
  assign unused_serve_wait = ^SERVE_WAIT;
`endif

  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    pos_x_d     = pos_x_q;
    pos_y_d     = pos_y_q;
    dir_x_d     = dir_x_q;
    dir_y_d     = dir_y_q;
    goal_l_d    = 1'b0;
    goal_r_d    = 1'b0;
    bounce_d    = 1'b0;
`ifdef BALL_SERVE_EN
    serve_cnt_d = serve_cnt_q;
`endif
    case (state_q)
      StWait: begin
        if (!run) begin
          frame_cnt_d = '0;
        end else if (tick) begin
          if (frame_cnt_q == FrameLast) begin
            frame_cnt_d = '0;
            state_d     = StMove;
          end else begin
            frame_cnt_d = frame_cnt_q + 8'd1;
          end
        end
      end
      StMove: begin
        pos_x_d  = x_res[9:0];
        dir_x_d  = x_res[10];
        pos_y_d  = y_res[9:0];
        dir_y_d  = y_res[10];
        goal_r_d = x_res[11] & dir_x_q;
        goal_l_d = x_res[11] & ~dir_x_q;
        bounce_d = x_res[11] | y_res[11];
        state_d  = StWait;
`ifdef BALL_SERVE_EN
        // The reflected dir_x already points away from the scorer.
        if (x_res[11]) begin
          state_d     = StServe;
          pos_x_d     = CtrX;
          pos_y_d     = CtrY;
          serve_cnt_d = '0;
        end
`endif
      end
`ifdef BALL_SERVE_EN
      StServe: begin
        if (tick) begin
          if (serve_cnt_q == ServeLast) begin
            serve_cnt_d = '0;
            frame_cnt_d = '0;
            state_d     = StWait;
          end else begin
            serve_cnt_d = serve_cnt_q + 16'd1;
          end
        end
      end
`endif
      default: state_d = StWait;
    endcase
  end

  always_ff @(posedge px_clk) begin
    if (!reset_n) begin
      state_q     <= StWait;
      vs_q        <= 1'b0;
      frame_cnt_q <= '0;
      pos_x_q     <= CtrX;
      pos_y_q     <= CtrY;
      dir_x_q     <= 1'b1;
      dir_y_q     <= 1'b1;
      goal_l_q    <= 1'b0;
      goal_r_q    <= 1'b0;
      bounce_q    <= 1'b0;
`ifdef BALL_SERVE_EN
      serve_cnt_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      vs_q        <= RGBStr_i[1];
      frame_cnt_q <= frame_cnt_d;
      pos_x_q     <= pos_x_d;
      pos_y_q     <= pos_y_d;
      dir_x_q     <= dir_x_d;
      dir_y_q     <= dir_y_d;
      goal_l_q    <= goal_l_d;
      goal_r_q    <= goal_r_d;
      bounce_q    <= bounce_d;
`ifdef BALL_SERVE_EN
      serve_cnt_q <= serve_cnt_d;
`endif
    end
  end

  assign pos_x  = pos_x_q;
  assign pos_y  = pos_y_q;
  assign goal_l = goal_l_q;
  assign goal_r = goal_r_q;
  assign bounce = bounce_q;

endmodule

// File: tb/tb_pxs_ball_ctrl.sv
// Bench for pxs_ball_ctrl: three instances (default, FRAME_DIV=3, 41x41 screen),
// directed checkpoint table plus hand sequences; serve test when BALL_SERVE_EN is set.
module tb_pxs_ball_ctrl;

  logic       clk = 1'b0;
  logic [2:0] rst_n = 3'b000;
  logic [2:0] vs = 3'b000;
  logic [2:0] run = 3'b000;
  logic [9:0] px [3];
  logic [9:0] py [3];
  logic       gl [3];
  logic       gr [3];
  logic       bo [3];

  int tests = 0;
  int fails = 0;
  int done [3] = '{0, 0, 0};

  always #5 clk = ~clk;

  pxs_ball_ctrl #(.SERVE_WAIT(4)) u_a (
    .px_clk(clk), .reset_n(rst_n[0]), .RGBStr_i({24'd0, vs[0], 1'b0}), .run(run[0]),
    .pos_x(px[0]), .pos_y(py[0]), .goal_l(gl[0]), .goal_r(gr[0]), .bounce(bo[0])
  );

  pxs_ball_ctrl #(.FRAME_DIV(3), .SERVE_WAIT(4)) u_b (
    .px_clk(clk), .reset_n(rst_n[1]), .RGBStr_i({24'd0, vs[1], 1'b0}), .run(run[1]),
    .pos_x(px[1]), .pos_y(py[1]), .goal_l(gl[1]), .goal_r(gr[1]), .bounce(bo[1])
  );

  pxs_ball_ctrl #(.SCREEN_W(41), .SCREEN_H(41), .SERVE_WAIT(4)) u_c (
    .px_clk(clk), .reset_n(rst_n[2]), .RGBStr_i({24'd0, vs[2], 1'b0}), .run(run[2]),
    .pos_x(px[2]), .pos_y(py[2]), .goal_l(gl[2]), .goal_r(gr[2]), .bounce(bo[2])
  );

  typedef struct {
    int         d;
    int         moves;
    int         x;
    int         y;
    logic [2:0] p;  // {goal_l, goal_r, bounce}
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int d, input int m, input int x, input int y, input logic [2:0] p);
    vec_t v;
    v.d = d; v.moves = m; v.x = x; v.y = y; v.p = p;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_state(input string name, input int d, input int ex, input int ey,
                             input logic [2:0] ep);
    check({name, " pos_x"}, 32'(px[d]), ex);
    check({name, " pos_y"}, 32'(py[d]), ey);
    check({name, " pulses"}, 32'({gl[d], gr[d], bo[d]}), 32'(ep));
  endtask

  task automatic do_reset(input int d, input int cx, input int cy);
    rst_n[d] = 1'b0;
    vs[d]    = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check_state($sformatf("reset dut%0d", d), d, cx, cy, 3'b000);
    @(posedge clk);
    #1 rst_n[d] = 1'b1;
    done[d] = 0;
  endtask

  // One VS rising edge; returns at the negedge where the resulting move is visible.
  task automatic tick(input int d);
    @(posedge clk);
    #1 vs[d] = 1'b1;
    @(posedge clk);
    #1 vs[d] = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  int brun [14] = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 1, 1, 1};
  int bx   [14] = '{315, 315, 317, 317, 317, 319, 319, 319, 319, 319, 319, 319, 319, 321};

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, %0d tests run", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    // Basic motion and move latency on the default instance.
    run[0] = 1'b1;
    do_reset(0, 315, 235);
    @(posedge clk);
    #1 vs[0] = 1'b1;
    @(posedge clk);
    #1 vs[0] = 1'b0;
    @(negedge clk);
    check("latency move cycle pos_x", 32'(px[0]), 315);
    @(negedge clk);
    check_state("tick1", 0, 317, 237, 3'b000);
    tick(0);
    tick(0);
    check_state("tick3", 0, 321, 241, 3'b000);
    done[0] = 3;

    // Reset landing on a MOVE that would corner-bounce: no pulses, recentred.
    run[2] = 1'b1;
    do_reset(2, 15, 15);
    for (int i = 0; i < 7; i++) tick(2);
    check_state("pre-abort", 2, 29, 29, 3'b000);
    @(posedge clk);
    #1 vs[2] = 1'b1;
    @(posedge clk);
    #1 begin vs[2] = 1'b0; rst_n[2] = 1'b0; end
    @(posedge clk);
    @(negedge clk);
    check_state("abort", 2, 15, 15, 3'b000);
    @(posedge clk);
    #1 rst_n[2] = 1'b1;
    @(negedge clk);
    check_state("abort+1", 2, 15, 15, 3'b000);
    done[2] = 0;

    add(2, 1, 17, 17, 3'b000);
    add(2, 7, 29, 29, 3'b000);
`ifndef BALL_SERVE_EN
    add(2, 8, 31, 31, 3'b011);
    add(2, 9, 29, 29, 3'b000);
    add(2, 23, 1, 1, 3'b000);
    add(2, 24, 0, 0, 3'b101);
    add(2, 25, 2, 2, 3'b000);
`endif
    add(0, 117, 549, 469, 3'b000);
    add(0, 118, 551, 470, 3'b001);
    add(0, 119, 553, 468, 3'b000);
    add(0, 157, 629, 392, 3'b000);
`ifdef BALL_SERVE_EN
    add(0, 158, 315, 235, 3'b011);
`else
    add(0, 158, 630, 390, 3'b011);
    add(0, 159, 628, 388, 3'b000);
    add(0, 352, 242, 2, 3'b000);
    add(0, 353, 240, 0, 3'b001);
    add(0, 354, 238, 2, 3'b000);
    add(0, 472, 2, 238, 3'b000);
    add(0, 473, 0, 240, 3'b101);
    add(0, 474, 2, 242, 3'b000);
`endif

    foreach (vecs[k]) begin
      while (done[vecs[k].d] < vecs[k].moves) begin
        tick(vecs[k].d);
        done[vecs[k].d]++;
      end
      check_state($sformatf("vec%0d dut%0d move%0d", k, vecs[k].d, vecs[k].moves), vecs[k].d,
                  vecs[k].x, vecs[k].y, vecs[k].p);
      @(negedge clk);
      check($sformatf("vec%0d pulse width", k),
            32'({gl[vecs[k].d], gr[vecs[k].d], bo[vecs[k].d]}), 0);
    end

`ifdef BALL_SERVE_EN
    // Serve hold: centre for SERVE_WAIT ticks regardless of run, then dir_x away.
    for (int i = 0; i < 4; i++) begin
      run[0] = (i >= 2);
      tick(0);
      check_state($sformatf("serve hold %0d", i), 0, 315, 235, 3'b000);
    end
    run[0] = 1'b1;
    tick(0);
    check_state("serve release", 0, 313, 233, 3'b000);
`endif

    // Frame divider and freeze on the FRAME_DIV=3 instance.
    run[1] = 1'b1;
    do_reset(1, 315, 235);
    for (int i = 0; i < 14; i++) begin
      run[1] = brun[i][0];
      tick(1);
      check($sformatf("div tick%0d pos_x", i), 32'(px[1]), bx[i]);
      check($sformatf("div tick%0d pos_y", i), 32'(py[1]), bx[i] - 80);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
